// File: rtl/press_merge_2to1.sv
// ---------------------------------------------------------------------------
// press_merge_2to1
//
// Merges two press-event level inputs (in0 = channel A, in1 = channel B) into
// a single event stream tagged with its source channel. Every 0->1 edge on an
// input is one event. Events are counted per channel so none are lost while
// the consumer is busy, arbitrated round-robin when both channels have
// pending events, and offered over a valid/ready handshake.
//
// Parameters
//   CNT_W      width of each per-channel pending counter (saturates at
//              2**CNT_W-1, never wraps, never goes below 0). Minimum 2.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   in0        in   channel A press level
//   in1        in   channel B press level
//   out_ready  in   consumer accepts the offered event
//   clr_ovf    in   single-cycle pulse clearing ovf0/ovf1
//   out_valid  out  event offered
//   out_src    out  source of offered event: 0=in0, 1=in1
//   ovf0       out  sticky: an in0 event was dropped (counter saturated)
//   ovf1       out  sticky: an in1 event was dropped
//
// Build option
//   MERGE_IN_SYNC_EN  when defined, in0/in1 pass through a 2-flop
//                     synchronizer before edge detection (adds 2 cycles of
//                     latency). When undefined, in0/in1 must already be
//                     synchronous to clk.
// ---------------------------------------------------------------------------
module press_merge_2to1 #(
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in0,
    input  logic in1,
    input  logic out_ready,
    input  logic clr_ovf,
    output logic out_valid,
    output logic out_src,
    output logic ovf0,
    output logic ovf1
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Counter update: returns {overflow_event, next_count}.
    // A simultaneous rise and decrement is a net hold and never overflows.
    function automatic logic [CNT_W:0] cnt_next(
        input logic [CNT_W-1:0] cnt,
        input logic             rise,
        input logic             dec
    );
        logic [CNT_W:0] res;
        case ({rise, dec})
            2'b10: begin
                if (cnt == CNT_MAX) begin
                    res = {1'b1, cnt};
                end else begin
                    res = {1'b0, cnt + CNT_ONE};
                end
            end
            2'b01: begin
                if (cnt != CNT_ZERO) begin
                    res = {1'b0, cnt - CNT_ONE};
                end else begin
                    res = {1'b0, cnt};
                end
            end
            default: res = {1'b0, cnt};
        endcase
        return res;
    endfunction

    logic             in0_s;
    logic             in1_s;
    logic             in0_q;
    logic             in1_q;
    logic             rise0_s;
    logic             rise1_s;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;
    logic [CNT_W-1:0] cnt0_d;
    logic [CNT_W-1:0] cnt1_d;
    logic             ovf0_q;
    logic             ovf1_q;
    logic             ovf0_d;
    logic             ovf1_d;
    logic [CNT_W:0]   upd0_s;
    logic [CNT_W:0]   upd1_s;
    logic             any_s;
    logic             sel_s;
    logic             dec0_s;
    logic             dec1_s;
    state_t           state_q;
    logic             out_valid_q;
    logic             out_src_q;
    logic             last_grant_q;

`ifdef MERGE_IN_SYNC_EN
    logic [1:0] sync0_q;
    logic [1:0] sync1_q;

    // Two-flop synchronizers for asynchronous press inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_q <= 2'b00;
            sync1_q <= 2'b00;
        end else begin
            sync0_q <= {sync0_q[0], in0};
            sync1_q <= {sync1_q[0], in1};
        end
    end

    assign in0_s = sync0_q[1];
    assign in1_s = sync1_q[1];
`else
    assign in0_s = in0;
    assign in1_s = in1;
`endif

    assign rise0_s = in0_s & ~in0_q;
    assign rise1_s = in1_s & ~in1_q;

    // Channel selection and decrement strobes for the IDLE->OFFER transition.
    // On a tie the channel that did not win last time is chosen.
    always_comb begin
        any_s  = 1'b0;
        sel_s  = 1'b0;
        dec0_s = 1'b0;
        dec1_s = 1'b0;
        if ((cnt0_q != CNT_ZERO) && (cnt1_q != CNT_ZERO)) begin
            any_s = 1'b1;
            sel_s = ~last_grant_q;
        end else if (cnt0_q != CNT_ZERO) begin
            any_s = 1'b1;
            sel_s = 1'b0;
        end else if (cnt1_q != CNT_ZERO) begin
            any_s = 1'b1;
            sel_s = 1'b1;
        end else begin
            any_s = 1'b0;
            sel_s = 1'b0;
        end
        if ((state_q == ST_IDLE) && any_s) begin
            dec0_s = ~sel_s;
            dec1_s = sel_s;
        end else begin
            dec0_s = 1'b0;
            dec1_s = 1'b0;
        end
    end

    // Next pending counts and sticky overflow flags; a new overflow beats clr_ovf.
    always_comb begin
        upd0_s = cnt_next(cnt0_q, rise0_s, dec0_s);
        upd1_s = cnt_next(cnt1_q, rise1_s, dec1_s);
        cnt0_d = upd0_s[CNT_W-1:0];
        cnt1_d = upd1_s[CNT_W-1:0];
        ovf0_d = (ovf0_q & ~clr_ovf) | upd0_s[CNT_W];
        ovf1_d = (ovf1_q & ~clr_ovf) | upd1_s[CNT_W];
    end

    // Edge-detect history, pending counters and overflow flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            in0_q  <= 1'b0;
            in1_q  <= 1'b0;
            cnt0_q <= CNT_ZERO;
            cnt1_q <= CNT_ZERO;
            ovf0_q <= 1'b0;
            ovf1_q <= 1'b0;
        end else begin
            in0_q  <= in0_s;
            in1_q  <= in1_s;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            ovf0_q <= ovf0_d;
            ovf1_q <= ovf1_d;
        end
    end

    // Offer FSM with registered handshake outputs. last_grant resets to 1
    // so channel 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_s) begin
                        out_src_q   <= sel_s;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OFFER;
                    end else begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_OFFER: begin
                    if (out_ready) begin
                        out_valid_q  <= 1'b0;
                        last_grant_q <= out_src_q;
                        state_q      <= ST_IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OFFER;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;
    assign ovf0      = ovf0_q;
    assign ovf1      = ovf1_q;

endmodule

// File: tb/tb_press_merge_2to1.sv
// Directed testbench for press_merge_2to1 (instantiated with CNT_W=2 so the
// saturation case is reachable with a handful of presses).
module tb_press_merge_2to1;

`ifdef MERGE_IN_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk;
    logic rst;
    logic in0;
    logic in1;
    logic out_ready;
    logic clr_ovf;
    logic out_valid;
    logic out_src;
    logic ovf0;
    logic ovf1;

    int n_vec;
    int n_miss;
    int events;
    int src_err;

    press_merge_2to1 #(.CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0       (in0),
        .in1       (in1),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_src   (out_src),
        .ovf0      (ovf0),
        .ovf1      (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        for (int i = 0; i < SYNC_LAT; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press1();
        in1 = 1'b1;
        tick();
        in1 = 1'b0;
        tick();
    endtask

    task automatic press0();
        in0 = 1'b1;
        tick();
        in0 = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        rst       = 1'b1;
        in0       = 1'b0;
        in1       = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_src",   {31'd0, out_src},   32'd0);
        check("rst_ovf0",  {31'd0, ovf0},      32'd0);
        check("rst_ovf1",  {31'd0, ovf1},      32'd0);
        rst = 1'b0;
        tick();
        check("idle_valid", {31'd0, out_valid}, 32'd0);

        // Single event on in0 with out_ready=1
        out_ready = 1'b1;
        in0 = 1'b1;
        tick();
        settle();
        check("se_cnt0_1",   {30'd0, dut.cnt0_q}, 32'd1);
        check("se_valid_k",  {31'd0, out_valid},  32'd0);
        tick();
        check("se_valid_k1", {31'd0, out_valid},  32'd1);
        check("se_src",      {31'd0, out_src},    32'd0);
        check("se_cnt0_0",   {30'd0, dut.cnt0_q}, 32'd0);
        tick();
        check("se_valid_k2", {31'd0, out_valid},  32'd0);
        tick();
        tick();
        check("se_no_repeat", {31'd0, out_valid}, 32'd0);
        in0 = 1'b0;
        tick();

        // Tie / round-robin: twice from reset state of last_grant
        do_reset();
        for (int r = 0; r < 2; r++) begin
            in0 = 1'b1;
            in1 = 1'b1;
            tick();
            in0 = 1'b0;
            in1 = 1'b0;
            settle();
            check("tie_valid_pre", {31'd0, out_valid}, 32'd0);
            tick();
            check("tie_valid_a", {31'd0, out_valid}, 32'd1);
            check("tie_src_a",   {31'd0, out_src},   32'd0);
            tick();
            check("tie_gap",     {31'd0, out_valid}, 32'd0);
            tick();
            check("tie_valid_b", {31'd0, out_valid}, 32'd1);
            check("tie_src_b",   {31'd0, out_src},   32'd1);
            tick();
            check("tie_end",     {31'd0, out_valid}, 32'd0);
            tick();
        end

        // Backpressure: 3 presses on in1 with out_ready=0
        out_ready = 1'b0;
        press1();
        press1();
        press1();
        settle();
        tick();
        check("bp_valid", {31'd0, out_valid},  32'd1);
        check("bp_src",   {31'd0, out_src},    32'd1);
        check("bp_cnt1",  {30'd0, dut.cnt1_q}, 32'd2);
        out_ready = 1'b1;
        tick();
        check("bp_d0", {31'd0, out_valid}, 32'd0);
        tick();
        check("bp_d1", {31'd0, out_valid}, 32'd1);
        check("bp_s1", {31'd0, out_src},   32'd1);
        tick();
        check("bp_d2", {31'd0, out_valid}, 32'd0);
        tick();
        check("bp_d3", {31'd0, out_valid}, 32'd1);
        check("bp_s3", {31'd0, out_src},   32'd1);
        tick();
        check("bp_d4", {31'd0, out_valid}, 32'd0);
        check("bp_cnt1_end", {30'd0, dut.cnt1_q}, 32'd0);
        tick();

        // Saturation: 5 presses on in0 while offering, CNT_W=2 -> max 3
        out_ready = 1'b0;
        for (int p = 0; p < 5; p++) press0();
        settle();
        tick();
        check("sat_cnt0",  {30'd0, dut.cnt0_q}, 32'd3);
        check("sat_ovf0",  {31'd0, ovf0},       32'd1);
        check("sat_ovf1",  {31'd0, ovf1},       32'd0);
        check("sat_valid", {31'd0, out_valid},  32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("sat_clr", {31'd0, ovf0}, 32'd0);
        out_ready = 1'b1;
        events  = 1;
        src_err = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (out_valid) begin
                events++;
                if (out_src !== 1'b0) src_err++;
            end
        end
        check("sat_drain",    events,  32'd4);
        check("sat_drainsrc", src_err, 32'd0);

        // Reset mid-offer with cnt1=2
        out_ready = 1'b0;
        press1();
        press1();
        press1();
        settle();
        tick();
        check("rmo_pre_valid", {31'd0, out_valid},  32'd1);
        check("rmo_pre_cnt1",  {30'd0, dut.cnt1_q}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmo_valid", {31'd0, out_valid},  32'd0);
        check("rmo_cnt1",  {30'd0, dut.cnt1_q}, 32'd0);
        out_ready = 1'b1;
        events = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) events++;
        end
        check("rmo_no_events", events, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
